bomb_sched: RTL and testbench
=============================

Name: bomb_sched

Overview:
- Bomb-placement scheduler between the two player input controllers and the bomb-map update block.
- Accepts per-player place requests and validates them against the current bomb map, cooldown and per-player active-bomb limits.
- Arbitrates same-cell conflicts and emits the one-cycle bombA_v/bombB_v placement strobes with coordinates.
- Runs in the bomb clock domain; freezes when the game is over.

Parameters:
- MAX_BOMBS, 2, active bombs allowed per player (1..4).
- FUSE, 3, bombClk cycles a placed bomb counts as active against its owner.
- COOLDOWN, 1, bombClk cycles after a grant during which that player's next request stalls.

Ports:
- bombClk  input  1  bomb clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- game_state  input  2  0 = running; nonzero = game over.
- i_curBombMap_0  input  100  bomb map bit 0; cell index 10*x+y.
- i_curBombMap_1  input  100  bomb map bit 1; cell is free when both bits are 0.
- reqA  input  1  player A place request, level, held until ack/nack.
- reqA_x, reqA_y  input  4  requested cell for player A.
- reqB, reqB_x, reqB_y  input  1/4/4  same for player B.
- ackA, nackA, ackB, nackB  output  1  one-cycle response pulses.
- bombA_v, bombB_v  output  1  one-cycle placement strobes.
- bombA_x, bombA_y, bombB_x, bombB_y  output  4  placement coordinates, valid with the strobe.
- activeA, activeB  output  3  current active-bomb count per player.

Behaviour:
- Reset (rst high at an edge): all pulses 0; coords 0; activeA/activeB 0; all FUSE slot counters 0; cooldowns 0; both player FSMs to IDLE; rr_ptr = A. Reset mid-handshake drops the request silently: no ack or nack is issued.
- Per-player FSM, IDLE -> WAIT_LOW:
  - In IDLE with req high, the request is evaluated at this edge.
  - On ack or nack, go to WAIT_LOW.
  - WAIT_LOW -> IDLE once req is sampled low. A held req is never re-evaluated.
- Evaluation order at an edge; the first match wins:
  - (a) game_state != 0 -> nack.
  - (b) x or y outside 1..8 -> nack.
  - (c) map cell not 00 -> nack.
  - (d) active count == MAX_BOMBS -> nack.
  - (e) cooldown != 0 -> stall: no response, stay IDLE, re-evaluate next edge.
  - (f) otherwise grant.
- Conflict: both players eligible for a grant on the same (x,y) at the same edge.
  - Player at rr_ptr is granted; the other stalls one cycle.
  - rr_ptr flips to the loser.
  - On re-evaluation the loser is nacked by (c) once the map shows the cell, or by a comparison against a registered last-grant cell (held 1 cycle), whichever comes first.
- Different cells: both granted at the same edge.
- Grant at edge k produces, all registered and visible after edge k, high exactly one cycle:
  - ackX = 1 and bombX_v = 1;
  - bombX_x/bombX_y = request coords;
  - cooldownX loaded with COOLDOWN;
  - one free slot loaded with FUSE, lowest index first.
- Nack: nackX high one cycle; no state change other than the FSM.
- Slots: each nonzero slot decrements by 1 per edge.
  - activeX = number of nonzero slots, updated the edge after any load or expiry.
  - A slot reaching 0 and a new grant at the same edge: the grant may reuse that slot.
- Cooldown decrements to 0 and saturates; COOLDOWN = 0 means no stall.
- ack/nack/bomb_v are never high in the same cycle for one player; bombX_v is 0 whenever ackX is 0.
- game_state != 0: no grants at all; slots and cooldowns keep counting down.

Test Plan:
- Reset, then reqA at (3,4) on an empty map -> ackA=1, bombA_v=1, bombA_x=3, bombA_y=4 for exactly one cycle after the edge; activeA=1 the next cycle; no second ack while reqA stays high.
- reqA at (0,5), then (9,2), then a request on a map cell with bits 01 -> three nackA pulses, bombA_v never asserted.
- MAX_BOMBS=2: three A grants at distinct cells, each req dropped and re-raised between them -> third is nacked with activeA=2; after FUSE cycles, activeA reaches 0 and a new request is acked.
- COOLDOWN=1: reqA re-raised on the first cycle after an ack -> no response for 1 edge, then ack.
- reqA and reqB both at (5,5), rr_ptr=A -> ackA only; reqB stalls, is then nacked; rr_ptr=B. Repeat at a fresh cell -> B wins.
- game_state=2 with reqA and reqB valid -> nackA and nackB, no strobes. Separately, assert rst while reqB is pending under cooldown -> all outputs 0 next cycle, no response pulse.

Source files
------------

// File: rtl/bomb_sched_if.sv
// Bomb scheduler bus: player place requests and bomb map in, response pulses,
// placement strobes and active-bomb counts out.
interface bomb_sched_if;
  logic [1:0]  game_state;
  logic [99:0] i_curBombMap_0;
  logic [99:0] i_curBombMap_1;

  logic        reqA;
  logic [3:0]  reqA_x;
  logic [3:0]  reqA_y;
  logic        reqB;
  logic [3:0]  reqB_x;
  logic [3:0]  reqB_y;

  logic        ackA;
  logic        nackA;
  logic        ackB;
  logic        nackB;
  logic        bombA_v;
  logic        bombB_v;
  logic [3:0]  bombA_x;
  logic [3:0]  bombA_y;
  logic [3:0]  bombB_x;
  logic [3:0]  bombB_y;
  logic [2:0]  activeA;
  logic [2:0]  activeB;

  // Player controllers and map owner side
  modport master (
    output game_state, i_curBombMap_0, i_curBombMap_1,
    output reqA, reqA_x, reqA_y, reqB, reqB_x, reqB_y,
    input  ackA, nackA, ackB, nackB, bombA_v, bombB_v,
    input  bombA_x, bombA_y, bombB_x, bombB_y, activeA, activeB
  );

  // Scheduler side
  modport slave (
    input  game_state, i_curBombMap_0, i_curBombMap_1,
    input  reqA, reqA_x, reqA_y, reqB, reqB_x, reqB_y,
    output ackA, nackA, ackB, nackB, bombA_v, bombB_v,
    output bombA_x, bombA_y, bombB_x, bombB_y, activeA, activeB
  );
endinterface

// File: rtl/bomb_sched.sv
// Bomb-placement scheduler: validates per-player place requests against the
// bomb map, fuse slots and cooldown, arbitrates same-cell conflicts round-robin
// and emits registered one-cycle ack/nack and placement strobes.
module bomb_sched #(
  parameter int unsigned MAX_BOMBS = 2,
  parameter int unsigned FUSE      = 3,
  parameter int unsigned COOLDOWN  = 1
) (
  input logic         bombClk,
  input logic         rst,
  bomb_sched_if.slave bus
);

  localparam int unsigned FuseW = $clog2(FUSE + 1);
  localparam int unsigned CoolW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam logic [FuseW-1:0] FuseLoad = FuseW'(FUSE);
  localparam logic [CoolW-1:0] CoolLoad = CoolW'(COOLDOWN);
  localparam logic [2:0]       MaxCnt   = 3'(MAX_BOMBS);

  typedef enum logic [0:0] {
    StIdle,
    StWaitLow
  } plState_e;

  // Index 0 is player A, index 1 is player B throughout.
  logic         req  [2];
  logic [3:0]   reqX [2];
  logic [3:0]   reqY [2];
  logic [127:0] mapBusy;
  logic         gameOver;

  assign req[0]   = bus.reqA;
  assign reqX[0]  = bus.reqA_x;
  assign reqY[0]  = bus.reqA_y;
  assign req[1]   = bus.reqB;
  assign reqX[1]  = bus.reqB_x;
  assign reqY[1]  = bus.reqB_y;
  // Padded so any 7-bit cell index stays inside the vector.
  assign mapBusy  = {28'b0, bus.i_curBombMap_0 | bus.i_curBombMap_1};
  assign gameOver = |bus.game_state;

  // Registered state
  plState_e         state_q [2];
  plState_e         state_d [2];
  logic [FuseW-1:0] slot_q  [2][MAX_BOMBS];
  logic [FuseW-1:0] slot_d  [2][MAX_BOMBS];
  logic [CoolW-1:0] cool_q  [2];
  logic [CoolW-1:0] cool_d  [2];
  // Cell granted at the previous edge, blocks a stalled conflict loser.
  logic             lastV_q [2];
  logic [3:0]       lastX_q [2];
  logic [3:0]       lastY_q [2];
  logic             rrPtr_q;  // 0: A wins next conflict, 1: B wins
  logic             rrPtr_d;

  // Registered outputs
  logic             ack_q   [2];
  logic             nack_q  [2];
  logic             bv_q    [2];
  logic [3:0]       bx_q    [2];
  logic [3:0]       by_q    [2];
  logic [2:0]       act_q   [2];

  // Request classification
  logic [2:0]       activeCnt [2];
  logic             inRange   [2];
  logic [6:0]       cellIdx   [2];
  logic             cellBusy  [2];
  logic             evaluate  [2];
  logic             nackNow   [2];
  logic             eligible  [2];
  logic             grant     [2];
  logic             conflict;

  // Classify each pending request and arbitrate same-cell conflicts
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      activeCnt[p] = 3'd0;
      for (int i = 0; i < int'(MAX_BOMBS); i++) begin
        if (slot_q[p][i] != '0) begin
          activeCnt[p] = activeCnt[p] + 3'd1;
        end
      end
      inRange[p] = (reqX[p] >= 4'd1) && (reqX[p] <= 4'd8) &&
                   (reqY[p] >= 4'd1) && (reqY[p] <= 4'd8);
      cellIdx[p] = 7'(reqX[p]) * 7'd10 + 7'(reqY[p]);
      cellBusy[p] = inRange[p] && mapBusy[cellIdx[p]];
      for (int q = 0; q < 2; q++) begin
        if (lastV_q[q] && (lastX_q[q] == reqX[p]) && (lastY_q[q] == reqY[p])) begin
          cellBusy[p] = 1'b1;
        end
      end
      evaluate[p] = (state_q[p] == StIdle) && req[p];
      nackNow[p]  = evaluate[p] &&
                    (gameOver || !inRange[p] || cellBusy[p] || (activeCnt[p] == MaxCnt));
      // Cooldown only stalls; it never produces a response.
      eligible[p] = evaluate[p] && !nackNow[p] && (cool_q[p] == '0);
    end
    conflict = eligible[0] && eligible[1] &&
               (reqX[0] == reqX[1]) && (reqY[0] == reqY[1]);
    grant[0] = eligible[0] && !(conflict && rrPtr_q);
    grant[1] = eligible[1] && !(conflict && !rrPtr_q);
    // Pointer moves to the loser so it wins the next conflict.
    rrPtr_d  = conflict ? !rrPtr_q : rrPtr_q;
  end

  // Count down fuse slots and cooldowns; load them on a grant
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      logic loaded;
      loaded = 1'b0;
      cool_d[p] = (cool_q[p] != '0) ? cool_q[p] - CoolW'(1) : '0;
      if (grant[p]) begin
        cool_d[p] = CoolLoad;
      end
      for (int i = 0; i < int'(MAX_BOMBS); i++) begin
        slot_d[p][i] = (slot_q[p][i] != '0) ? slot_q[p][i] - FuseW'(1) : '0;
        // A slot expiring on this edge counts as free for the new bomb.
        if (grant[p] && !loaded && (slot_d[p][i] == '0)) begin
          slot_d[p][i] = FuseLoad;
          loaded       = 1'b1;
        end
      end
    end
  end

  // Handshake FSM next state: respond once, then wait for req to drop
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      state_d[p] = state_q[p];
      unique case (state_q[p])
        StIdle: begin
          if (grant[p] || nackNow[p]) begin
            state_d[p] = StWaitLow;
          end
        end
        StWaitLow: begin
          if (!req[p]) begin
            state_d[p] = StIdle;
          end
        end
        default: state_d[p] = StIdle;
      endcase
    end
  end

  // Handshake FSM state register
  always_ff @(posedge bombClk) begin
    for (int p = 0; p < 2; p++) begin
      if (rst) begin
        state_q[p] <= StIdle;
      end else begin
        state_q[p] <= state_d[p];
      end
    end
  end

  // Fuse slots, cooldowns, last-grant cells and round-robin pointer
  always_ff @(posedge bombClk) begin
    if (rst) begin
      for (int p = 0; p < 2; p++) begin
        for (int i = 0; i < int'(MAX_BOMBS); i++) begin
          slot_q[p][i] <= '0;
        end
        cool_q[p]  <= '0;
        lastV_q[p] <= 1'b0;
        lastX_q[p] <= 4'd0;
        lastY_q[p] <= 4'd0;
      end
      rrPtr_q <= 1'b0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        for (int i = 0; i < int'(MAX_BOMBS); i++) begin
          slot_q[p][i] <= slot_d[p][i];
        end
        cool_q[p]  <= cool_d[p];
        lastV_q[p] <= grant[p];
        lastX_q[p] <= reqX[p];
        lastY_q[p] <= reqY[p];
      end
      rrPtr_q <= rrPtr_d;
    end
  end

  // Registered response pulses, placement strobes and active counts
  always_ff @(posedge bombClk) begin
    if (rst) begin
      for (int p = 0; p < 2; p++) begin
        ack_q[p]  <= 1'b0;
        nack_q[p] <= 1'b0;
        bv_q[p]   <= 1'b0;
        bx_q[p]   <= 4'd0;
        by_q[p]   <= 4'd0;
        act_q[p]  <= 3'd0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        ack_q[p]  <= grant[p];
        nack_q[p] <= nackNow[p];
        bv_q[p]   <= grant[p];
        if (grant[p]) begin
          bx_q[p] <= reqX[p];
          by_q[p] <= reqY[p];
        end
        act_q[p] <= activeCnt[p];
      end
    end
  end

  assign bus.ackA    = ack_q[0];
  assign bus.nackA   = nack_q[0];
  assign bus.bombA_v = bv_q[0];
  assign bus.bombA_x = bx_q[0];
  assign bus.bombA_y = by_q[0];
  assign bus.activeA = act_q[0];
  assign bus.ackB    = ack_q[1];
  assign bus.nackB   = nack_q[1];
  assign bus.bombB_v = bv_q[1];
  assign bus.bombB_x = bx_q[1];
  assign bus.bombB_y = by_q[1];
  assign bus.activeB = act_q[1];

endmodule

// File: tb/tb_bomb_sched.sv
// Bench for bomb_sched: directed scenarios plus randomized traffic, every cycle
// compared against a time-based reference model of the placement rules.
module tb_bomb_sched;

  localparam int MaxBombs = 2;
  localparam int Fuse     = 8;
  localparam int Cooldown = 2;

  logic bombClk;
  logic rst;
  bomb_sched_if bus ();

  bomb_sched #(
    .MAX_BOMBS(MaxBombs),
    .FUSE     (Fuse),
    .COOLDOWN (Cooldown)
  ) dut (
    .bombClk(bombClk),
    .rst    (rst),
    .bus    (bus)
  );

  initial bombClk = 1'b0;
  always #5 bombClk = ~bombClk;

  int checkCount = 0;
  int errCount   = 0;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: bombs are remembered by the edge they were granted on.
  int edgeNo = 0;
  bit mWait      [2];
  int grantEdges [2][$];
  int lastGrant  [2];
  int recEdge    [2];
  int recX       [2];
  int recY       [2];
  bit rrB;
  int eAck [2], eNack [2], eV [2], eX [2], eY [2], eAct [2];

  task automatic modelReset();
    for (int p = 0; p < 2; p++) begin
      mWait[p] = 0;
      grantEdges[p].delete();
      lastGrant[p] = -1000;
      recEdge[p] = -1000;
      recX[p] = 0;
      recY[p] = 0;
      eAck[p] = 0; eNack[p] = 0; eV[p] = 0; eX[p] = 0; eY[p] = 0; eAct[p] = 0;
    end
    rrB = 0;
  endtask

  task automatic modelStep();
    bit req [2];
    int x [2], y [2];
    bit evalP [2], nk [2], elig [2], gr [2];
    bit inR, busy, conflict;
    int act [2];
    req[0] = bus.reqA; x[0] = int'(bus.reqA_x); y[0] = int'(bus.reqA_y);
    req[1] = bus.reqB; x[1] = int'(bus.reqB_x); y[1] = int'(bus.reqB_y);
    if (rst) begin
      modelReset();
    end else begin
      for (int p = 0; p < 2; p++) begin
        while (grantEdges[p].size() > 0 && grantEdges[p][0] < edgeNo - Fuse)
          void'(grantEdges[p].pop_front());
        act[p] = grantEdges[p].size();
        evalP[p] = !mWait[p] && req[p];
        inR = x[p] >= 1 && x[p] <= 8 && y[p] >= 1 && y[p] <= 8;
        busy = 0;
        if (inR) busy = bus.i_curBombMap_0[10*x[p]+y[p]] | bus.i_curBombMap_1[10*x[p]+y[p]];
        for (int q = 0; q < 2; q++)
          if (recEdge[q] == edgeNo - 1 && recX[q] == x[p] && recY[q] == y[p]) busy = 1;
        nk[p] = evalP[p] && (bus.game_state != 0 || !inR || busy || act[p] == MaxBombs);
        elig[p] = evalP[p] && !nk[p] && (edgeNo - lastGrant[p] > Cooldown);
      end
      conflict = elig[0] && elig[1] && x[0] == x[1] && y[0] == y[1];
      gr[0] = elig[0] && !(conflict && rrB);
      gr[1] = elig[1] && !(conflict && !rrB);
      if (conflict) rrB = !rrB;
      for (int p = 0; p < 2; p++) begin
        eAck[p] = gr[p]; eNack[p] = nk[p]; eV[p] = gr[p]; eAct[p] = act[p];
        if (gr[p]) begin
          eX[p] = x[p]; eY[p] = y[p];
          grantEdges[p].push_back(edgeNo);
          lastGrant[p] = edgeNo;
          recEdge[p] = edgeNo; recX[p] = x[p]; recY[p] = y[p];
        end
        if (evalP[p] && (gr[p] || nk[p])) mWait[p] = 1;
        else if (mWait[p] && !req[p]) mWait[p] = 0;
      end
    end
    edgeNo++;
  endtask

  task automatic compareAll();
    checkEq("ackA",    32'(bus.ackA),    eAck[0]);
    checkEq("nackA",   32'(bus.nackA),   eNack[0]);
    checkEq("bombA_v", 32'(bus.bombA_v), eV[0]);
    checkEq("bombA_x", 32'(bus.bombA_x), eX[0]);
    checkEq("bombA_y", 32'(bus.bombA_y), eY[0]);
    checkEq("activeA", 32'(bus.activeA), eAct[0]);
    checkEq("ackB",    32'(bus.ackB),    eAck[1]);
    checkEq("nackB",   32'(bus.nackB),   eNack[1]);
    checkEq("bombB_v", 32'(bus.bombB_v), eV[1]);
    checkEq("bombB_x", 32'(bus.bombB_x), eX[1]);
    checkEq("bombB_y", 32'(bus.bombB_y), eY[1]);
    checkEq("activeB", 32'(bus.activeB), eAct[1]);
  endtask

  // One clock: model the edge, compare just after it, return on the falling edge.
  task automatic cycle();
    @(posedge bombClk);
    modelStep();
    #1;
    compareAll();
    @(negedge bombClk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic setReq(input int p, input bit r, input int x, input int y);
    if (p == 0) begin
      bus.reqA = r; bus.reqA_x = 4'(x); bus.reqA_y = 4'(y);
    end else begin
      bus.reqB = r; bus.reqB_x = 4'(x); bus.reqB_y = 4'(y);
    end
  endtask

  function automatic logic ackOf(input int p);
    return (p == 0) ? bus.ackA : bus.ackB;
  endfunction

  function automatic logic respOf(input int p);
    return (p == 0) ? (bus.ackA | bus.nackA) : (bus.ackB | bus.nackB);
  endfunction

  // Raise a request, hold it until answered, then drop it for one edge.
  task automatic doReq(input int p, input int x, input int y,
                       output logic [31:0] gotAck, output logic [31:0] gotAct);
    int n;
    setReq(p, 1, x, y);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!(eAck[p] != 0 || eNack[p] != 0) && n < 12);
    if (!(eAck[p] != 0 || eNack[p] != 0)) checkEq("resp_timeout", 32'(respOf(p)), 1);
    gotAck = 32'(ackOf(p));
    gotAct = (p == 0) ? 32'(bus.activeA) : 32'(bus.activeB);
    setReq(p, 0, x, y);
    cycle();
  endtask

  initial begin
    logic [31:0] ga, gc;
    bit curReq [2];
    int rx, ry;

    rst = 1'b1;
    bus.game_state = 2'd0;
    bus.i_curBombMap_0 = '0;
    bus.i_curBombMap_1 = '0;
    setReq(0, 0, 0, 0);
    setReq(1, 0, 0, 0);
    modelReset();
    idle(2);
    checkEq("reset_activeA", 32'(bus.activeA), 0);
    checkEq("reset_ackA", 32'(bus.ackA), 0);
    rst = 1'b0;
    cycle();

    // Single grant on an empty map, held request is not re-evaluated
    setReq(0, 1, 3, 4);
    cycle();
    checkEq("t1_ackA", 32'(bus.ackA), 1);
    checkEq("t1_bombA_v", 32'(bus.bombA_v), 1);
    checkEq("t1_bombA_x", 32'(bus.bombA_x), 3);
    checkEq("t1_bombA_y", 32'(bus.bombA_y), 4);
    cycle();
    checkEq("t1_ackA_once", 32'(bus.ackA), 0);
    checkEq("t1_activeA", 32'(bus.activeA), 1);
    idle(2);
    setReq(0, 0, 3, 4);
    cycle();

    // Out-of-range and occupied cells are nacked
    doReq(0, 0, 5, ga, gc);
    checkEq("t2_nack_x0", ga, 0);
    doReq(0, 9, 2, ga, gc);
    checkEq("t2_nack_x9", ga, 0);
    bus.i_curBombMap_0[66] = 1'b1;
    doReq(0, 6, 6, ga, gc);
    checkEq("t2_nack_map01", ga, 0);
    bus.i_curBombMap_0 = '0;

    // Active-bomb limit, then recovery after the fuse runs out
    idle(Fuse + 1);
    doReq(0, 1, 1, ga, gc);
    checkEq("t3_first_ack", ga, 1);
    doReq(0, 1, 2, ga, gc);
    checkEq("t3_second_ack", ga, 1);
    doReq(0, 1, 3, ga, gc);
    checkEq("t3_third_ack", ga, 0);
    checkEq("t3_third_active", gc, 2);
    idle(Fuse + 1);
    checkEq("t3_drained", 32'(bus.activeA), 0);
    doReq(0, 1, 4, ga, gc);
    checkEq("t3_after_fuse_ack", ga, 1);

    // Cooldown stall on an immediate re-request
    idle(Fuse + 1);
    doReq(0, 2, 2, ga, gc);
    setReq(0, 1, 7, 7);
    cycle();
    checkEq("t4_stall_resp", 32'(bus.ackA | bus.nackA), 0);
    cycle();
    checkEq("t4_ack_after_stall", 32'(bus.ackA), 1);
    setReq(0, 0, 7, 7);
    cycle();

    // Same-cell conflicts alternate the winner
    idle(Fuse + 1);
    setReq(0, 1, 5, 5);
    setReq(1, 1, 5, 5);
    cycle();
    checkEq("t5_ackA", 32'(bus.ackA), 1);
    checkEq("t5_B_stall", 32'(bus.ackB | bus.nackB), 0);
    cycle();
    checkEq("t5_nackB", 32'(bus.nackB), 1);
    setReq(0, 0, 5, 5);
    setReq(1, 0, 5, 5);
    idle(Fuse + 1);
    setReq(0, 1, 4, 7);
    setReq(1, 1, 4, 7);
    cycle();
    checkEq("t5_ackB", 32'(bus.ackB), 1);
    checkEq("t5_A_stall", 32'(bus.ackA | bus.nackA), 0);
    cycle();
    checkEq("t5_nackA", 32'(bus.nackA), 1);
    setReq(0, 0, 4, 7);
    setReq(1, 0, 4, 7);
    idle(Fuse + 1);

    // Game over nacks both players
    bus.game_state = 2'd2;
    setReq(0, 1, 2, 3);
    setReq(1, 1, 3, 2);
    cycle();
    checkEq("t6_nackA", 32'(bus.nackA), 1);
    checkEq("t6_nackB", 32'(bus.nackB), 1);
    checkEq("t6_no_strobe", 32'(bus.bombA_v | bus.bombB_v), 0);
    setReq(0, 0, 2, 3);
    setReq(1, 0, 3, 2);
    bus.game_state = 2'd0;
    cycle();

    // Reset while B is stalled by cooldown drops the request silently
    doReq(1, 6, 2, ga, gc);
    checkEq("t7_ackB", ga, 1);
    setReq(1, 1, 6, 3);
    cycle();
    checkEq("t7_stall", 32'(bus.ackB | bus.nackB), 0);
    rst = 1'b1;
    cycle();
    checkEq("t7_rst_resp", 32'(bus.ackB | bus.nackB | bus.bombB_v), 0);
    checkEq("t7_rst_bombB_x", 32'(bus.bombB_x), 0);
    checkEq("t7_rst_activeB", 32'(bus.activeB), 0);
    rst = 1'b0;
    setReq(1, 0, 6, 3);
    cycle();
    checkEq("t7_after_rst", 32'(bus.ackB | bus.nackB), 0);

    // Randomized traffic
    curReq[0] = 0;
    curReq[1] = 0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 64 == 0) begin
        for (int i = 0; i < 100; i++) begin
          bus.i_curBombMap_0[i] = ($urandom_range(0, 11) == 0);
          bus.i_curBombMap_1[i] = ($urandom_range(0, 15) == 0);
        end
      end
      bus.game_state = ($urandom_range(0, 24) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      rst = ($urandom_range(0, 299) == 0);
      for (int p = 0; p < 2; p++) begin
        if (!curReq[p]) begin
          if ($urandom_range(0, 2) == 0) begin
            rx = ($urandom_range(0, 19) == 0) ? int'($urandom_range(9, 15))
                                              : int'($urandom_range(0, 9));
            ry = ($urandom_range(0, 19) == 0) ? int'($urandom_range(9, 15))
                                              : int'($urandom_range(0, 9));
            if (p == 1 && curReq[0] && $urandom_range(0, 1) == 0) begin
              rx = int'(bus.reqA_x);
              ry = int'(bus.reqA_y);
            end
            setReq(p, 1, rx, ry);
            curReq[p] = 1;
          end
        end else if (mWait[p] && $urandom_range(0, 1) == 0) begin
          setReq(p, 0, 0, 0);
          curReq[p] = 0;
        end
      end
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
